fib_seq_engine: RTL

- Parameterised successor to the lab-2 Fibonacci datapath.
- Computes term n of a two-seed additive sequence. Mode selects Fibonacci (F0=0, F1=1) or Lucas (L0=2, L1=1).
- Per-result overflow detection that is exact, not conservative.
- Same go/done handshake the team's BFM drives: sits directly under the fib BFM interface in the lab testbench.

---
 rtl/fib_seq_engine.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fib_seq_engine.sv
// fib_seq_engine: computes term n of a two-seed additive sequence.
//   mode=0 -> Fibonacci (seeds 0,1), mode=1 -> Lucas (seeds 2,1).
// Arithmetic is modulo 2^OUTPUT_WIDTH. The overflow flag is exact: it is
// set only when the true value of term n does not fit in OUTPUT_WIDTH bits.
// Optional build macro: FIB_ABORT_EN adds an 'abort' input that cancels an
// in-flight computation without raising done.
module fib_seq_engine #(
  parameter int INPUT_WIDTH  = 6,
  parameter int OUTPUT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic [INPUT_WIDTH-1:0]  n,
  input  logic                    mode,
`ifdef FIB_ABORT_EN
  input  logic                    abort,
`endif
  output logic [OUTPUT_WIDTH-1:0] result,
  output logic                    overflow,
  output logic                    done,
  output logic                    busy
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COMPUTE = 1'b1
  } state_t;

  // First seed: 0 for Fibonacci, 2 for Lucas (mode lands on bit 1).
  function automatic logic [OUTPUT_WIDTH-1:0] seed0_f(input logic m);
    seed0_f = {{(OUTPUT_WIDTH-2){1'b0}}, m, 1'b0};
  endfunction

  // Second seed: 1 in both modes.
  function automatic logic [OUTPUT_WIDTH-1:0] seed1_f();
    seed1_f = {{(OUTPUT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Sticky overflow for the new look-ahead term: it has overflowed if either
  // operand already had, or if the addition itself carried out.
  function automatic logic next_ovf_f(input logic a_ovf, input logic b_ovf,
                                      input logic carry);
    next_ovf_f = a_ovf | b_ovf | carry;
  endfunction

  state_t                  r_state;
  logic [OUTPUT_WIDTH-1:0] r_x;        // current term (term n - i)
  logic [OUTPUT_WIDTH-1:0] r_y;        // look-ahead term (term n - i + 1)
  logic                    r_xo;       // true value of r_x exceeds width
  logic                    r_yo;       // true value of r_y exceeds width
  logic [INPUT_WIDTH-1:0]  r_i;        // remaining iterations
  logic [OUTPUT_WIDTH-1:0] r_result;
  logic                    r_overflow;
  logic                    r_done;
  logic                    r_busy;

  logic [OUTPUT_WIDTH:0]   w_sum;
  logic                    w_carry;
  logic [OUTPUT_WIDTH-1:0] w_sum_lo;
  logic                    w_last;
  logic                    w_abort;

`ifdef FIB_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // One iteration step: widened add so the carry out is exact.
  always_comb begin
    w_sum    = {1'b0, r_x} + {1'b0, r_y};
    w_carry  = w_sum[OUTPUT_WIDTH];
    w_sum_lo = w_sum[OUTPUT_WIDTH-1:0];
    w_last   = (r_i == {INPUT_WIDTH{1'b0}});
  end

  // Control FSM and datapath; every output is driven from a register here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_x        <= {OUTPUT_WIDTH{1'b0}};
      r_y        <= {OUTPUT_WIDTH{1'b0}};
      r_xo       <= 1'b0;
      r_yo       <= 1'b0;
      r_i        <= {INPUT_WIDTH{1'b0}};
      r_result   <= {OUTPUT_WIDTH{1'b0}};
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Abort has no meaning here; go is accepted even with done high.
          if (go) begin
            r_x     <= seed0_f(mode);
            r_y     <= seed1_f();
            r_xo    <= 1'b0;
            r_yo    <= 1'b0;
            r_i     <= n;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_COMPUTE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_COMPUTE: begin
          // go is ignored while computing; abort beats completion.
          if (w_abort) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_last) begin
            // Report term n only; r_yo (term n+1) is deliberately ignored.
            r_result   <= r_x;
            r_overflow <= r_xo;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_x     <= r_y;
            r_y     <= w_sum_lo;
            r_xo    <= r_yo;
            r_yo    <= next_ovf_f(r_xo, r_yo, w_carry);
            r_i     <= r_i - {{(INPUT_WIDTH-1){1'b0}}, 1'b1};
            r_state <= ST_COMPUTE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign result   = r_result;
  assign overflow = r_overflow;
  assign done     = r_done;
  assign busy     = r_busy;

endmodule
